load_store_unit: RTL and testbench

- Initiator side of the data memory's load/store request interface.
- Accepts decoded load/store ops from the execute stage into a small FIFO and computes effective addresses.
- Checks alignment and range, then drives the memory's pulse-style load and write request lines.
- Sign- or zero-extends load data and returns a tagged completion to writeback.

---
 rtl/load_store_unit.sv | 205 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store initiator: queues decoded ops, checks address legality, issues one
// pulse-style memory request at a time and returns a tagged, extended completion.
module load_store_unit #(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned ADDR_LIMIT   = 1024,
    parameter bit          STRICT_ALIGN = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic        issue_is_store,
    input  logic [2:0]  issue_funct3,
    input  logic [31:0] issue_base,
    input  logic [11:0] issue_offset,
    input  logic [31:0] issue_store_data,
    input  logic [4:0]  issue_tag,
    output logic        mem_load_request,
    output logic [31:0] mem_load_addr,
    input  logic [31:0] mem_read_data,
    output logic        mem_write_request,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    output logic [2:0]  mem_write_type,
    output logic        result_valid,
    output logic [4:0]  result_tag,
    output logic [31:0] result_data,
    output logic        result_error
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic        is_store;
        logic [2:0]  funct3;
        logic [31:0] base;
        logic [11:0] offset;
        logic [31:0] store_data;
        logic [4:0]  tag;
    } lsu_op_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t      state, next_state;
    lsu_op_t     fifo_mem [FIFO_DEPTH];
    lsu_op_t     push_op, head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic        push, pop;
    logic        cancelled;
    logic [2:0]  cur_funct3;
    logic        cur_is_store;

    logic [31:0] op_addr;
    logic [32:0] op_last;
    logic [2:0]  op_size;
    logic        op_legal, op_range_err, op_misaligned, op_error;
    logic [31:0] load_ext;

    assign issue_ready = (count < CNT_W'(FIFO_DEPTH)) && !flush;
    assign push        = issue_valid && issue_ready;
    assign head        = fifo_mem[rd_ptr];

    always_comb begin
        push_op.is_store   = issue_is_store;
        push_op.funct3     = issue_funct3;
        push_op.base       = issue_base;
        push_op.offset     = issue_offset;
        push_op.store_data = issue_store_data;
        push_op.tag        = issue_tag;
    end

    // Payload storage needs no reset; pointers and count gate its visibility.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_op;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Effective address, size and legality of the op at the FIFO head.
    always_comb begin
        op_addr  = head.base + {{20{head.offset[11]}}, head.offset};
        op_legal = 1'b0;
        op_size  = 3'd1;
        case (head.funct3)
            3'b000: begin op_legal = 1'b1; op_size = 3'd1; end
            3'b001: begin op_legal = 1'b1; op_size = 3'd2; end
            3'b010: begin op_legal = 1'b1; op_size = 3'd4; end
            3'b100: begin op_legal = !head.is_store; op_size = 3'd1; end
            3'b101: begin op_legal = !head.is_store; op_size = 3'd2; end
            default: ;
        endcase
        op_last       = {1'b0, op_addr} + 33'(op_size) - 33'd1;
        op_range_err  = op_last >= 33'(ADDR_LIMIT);
        op_misaligned = STRICT_ALIGN &&
                        ((op_size == 3'd2 && op_addr[0]) ||
                         (op_size == 3'd4 && op_addr[1:0] != 2'b00));
        op_error      = !op_legal || op_range_err || op_misaligned;
    end

    always_comb begin
        load_ext = 32'd0;
        case (cur_funct3)
            3'b000: load_ext = {{24{mem_read_data[7]}}, mem_read_data[7:0]};
            3'b001: load_ext = {{16{mem_read_data[15]}}, mem_read_data[15:0]};
            3'b010: load_ext = mem_read_data;
            3'b100: load_ext = {24'd0, mem_read_data[7:0]};
            3'b101: load_ext = {16'd0, mem_read_data[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0 && !flush) begin
                    pop        = 1'b1;
                    next_state = op_error ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: next_state = S_WAIT;
            S_WAIT:  next_state = (cancelled || flush) ? S_IDLE : S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Flushed in-flight ops still finish their access but lose their completion.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cancelled <= 1'b0;
        end else if (state == S_IDLE) begin
            cancelled <= 1'b0;
        end else if (flush && (state == S_ISSUE || state == S_WAIT)) begin
            cancelled <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_load_request  <= 1'b0;
            mem_load_addr     <= 32'd0;
            mem_write_request <= 1'b0;
            mem_write_addr    <= 32'd0;
            mem_write_data    <= 32'd0;
            mem_write_type    <= 3'd0;
            result_valid      <= 1'b0;
            result_tag        <= 5'd0;
            result_data       <= 32'd0;
            result_error      <= 1'b0;
            cur_funct3        <= 3'd0;
            cur_is_store      <= 1'b0;
        end else begin
            mem_load_request  <= pop && !op_error && !head.is_store;
            mem_write_request <= pop && !op_error && head.is_store;
            result_valid      <= (next_state == S_RESP);
            if (pop && !op_error) begin
                if (head.is_store) begin
                    mem_write_addr <= op_addr;
                    mem_write_data <= head.store_data;
                    mem_write_type <= head.funct3;
                end else begin
                    mem_load_addr  <= op_addr;
                end
            end
            if (pop) begin
                result_tag   <= head.tag;
                result_error <= op_error;
                result_data  <= 32'd0;
                cur_funct3   <= head.funct3;
                cur_is_store <= head.is_store;
            end
            if (state == S_WAIT && !cur_is_store) begin
                result_data <= load_ext;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table plus scoreboard of
// expected completions, with hand-written back-to-back, flush and reset sequences.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic        issue_is_store;
    logic [2:0]  issue_funct3;
    logic [31:0] issue_base;
    logic [11:0] issue_offset;
    logic [31:0] issue_store_data;
    logic [4:0]  issue_tag;
    logic        mem_load_request;
    logic [31:0] mem_load_addr;
    logic [31:0] mem_read_data;
    logic        mem_write_request;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic [2:0]  mem_write_type;
    logic        result_valid;
    logic [4:0]  result_tag;
    logic [31:0] result_data;
    logic        result_error;

    always #5 clock = ~clock;

    load_store_unit #(.FIFO_DEPTH(2), .ADDR_LIMIT(1024), .STRICT_ALIGN(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_is_store(issue_is_store), .issue_funct3(issue_funct3),
        .issue_base(issue_base), .issue_offset(issue_offset),
        .issue_store_data(issue_store_data), .issue_tag(issue_tag),
        .mem_load_request(mem_load_request), .mem_load_addr(mem_load_addr),
        .mem_read_data(mem_read_data),
        .mem_write_request(mem_write_request), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_write_type(mem_write_type),
        .result_valid(result_valid), .result_tag(result_tag),
        .result_data(result_data), .result_error(result_error)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [11:0] off;
        logic [31:0] sd;
        logic [4:0]  tag;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    // 1 KiB byte-addressed memory model on the far side of the request interface
    logic [7:0] mem [1024];
    bit         mem_init_done = 1'b0;
    logic [9:0] rd_a;
    int         cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
            mem_init_done <= 1'b1;
        end else if (reset_n && mem_write_request) begin
            mem[mem_write_addr[9:0]] <= mem_write_data[7:0];
            if (mem_write_type != 3'b000)
                mem[mem_write_addr[9:0] + 10'd1] <= mem_write_data[15:8];
            if (mem_write_type == 3'b010) begin
                mem[mem_write_addr[9:0] + 10'd2] <= mem_write_data[23:16];
                mem[mem_write_addr[9:0] + 10'd3] <= mem_write_data[31:24];
            end
        end
    end

    always_comb begin
        rd_a          = mem_load_addr[9:0];
        mem_read_data = {mem[rd_a + 10'd3], mem[rd_a + 10'd2], mem[rd_a + 10'd1], mem[rd_a]};
    end

    int          n_pass = 0;
    int          n_checks = 0;
    bit          prev_req = 1'b0;
    int          results_seen = 0;
    int          load_pulses = 0;
    int          write_pulses = 0;
    int          last_load_cyc = 0;
    int          last_write_cyc = 0;
    int          last_hs = 0;
    logic [31:0] last_load_addr = '0;
    logic [31:0] last_write_addr = '0;
    logic [31:0] last_write_data = '0;
    logic [2:0]  last_write_type = '0;
    exp_t        sb[$];
    vec_t        vecs[$];

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] base,
                                input logic [11:0] off, input logic [31:0] sd, input logic [4:0] tag,
                                input logic [31:0] ed, input logic ee);
        vec_t v;
        v.st = st; v.f3 = f3; v.base = base; v.off = off; v.sd = sd; v.tag = tag;
        v.exp_data = ed; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Advance to the next falling edge, then observe request pulses and completions.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        if (mem_load_request || mem_write_request) begin
            check("req_gap", 32'(prev_req), 32'd0);
            if (mem_load_request) begin
                load_pulses++;
                last_load_cyc  = cyc;
                last_load_addr = mem_load_addr;
            end
            if (mem_write_request) begin
                write_pulses++;
                last_write_cyc  = cyc;
                last_write_addr = mem_write_addr;
                last_write_data = mem_write_data;
                last_write_type = mem_write_type;
            end
        end
        prev_req = mem_load_request || mem_write_request;
        if (result_valid) begin
            results_seen++;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: tag %0d at cycle %0d, expected no result", result_tag, cyc);
            end else begin
                e = sb.pop_front();
                check("result_tag", 32'(result_tag), 32'(e.tag));
                check("result_data", result_data, e.data);
                check("result_error", 32'(result_error), 32'(e.err));
                check("result_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    endtask

    task automatic issue_op(input vec_t v, input int lat, input bit expect_res);
        int   waited;
        exp_t e;
        waited           = 0;
        issue_valid      = 1'b1;
        issue_is_store   = v.st;
        issue_funct3     = v.f3;
        issue_base       = v.base;
        issue_offset     = v.off;
        issue_store_data = v.sd;
        issue_tag        = v.tag;
        while (!issue_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (issue_ready) begin
            last_hs = cyc;
            if (expect_res) begin
                e.tag = v.tag; e.data = v.exp_data; e.err = v.exp_err; e.cyc = cyc + lat;
                sb.push_back(e);
            end
        end else begin
            n_checks++;
            $display("FAIL issue_timeout: ready low for %0d cycles, expected accept", waited);
        end
        tick();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        tick();
    endtask

    initial begin
        int          lp, wp, r0;
        vec_t        v;
        logic [31:0] ea;

        reset_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_is_store = 1'b0;
        issue_funct3 = 3'd0; issue_base = 32'd0; issue_offset = 12'd0;
        issue_store_data = 32'd0; issue_tag = 5'd0;

        //             st  f3      base           off     store data     tag  exp data       err
        vecs.push_back(mk(1, 3'b010, 32'h0000_0100, 12'h000, 32'hDEAD_BEEF, 5'd1,  32'h0000_0000, 0));
        vecs.push_back(mk(0, 3'b010, 32'h0000_0100, 12'h000, 32'h0,         5'd7,  32'hDEAD_BEEF, 0));
        vecs.push_back(mk(0, 3'b000, 32'h0000_0100, 12'h000, 32'h0,         5'd8,  32'hFFFF_FFEF, 0));
        vecs.push_back(mk(0, 3'b100, 32'h0000_0100, 12'h000, 32'h0,         5'd9,  32'h0000_00EF, 0));
        vecs.push_back(mk(0, 3'b001, 32'h0000_0102, 12'h000, 32'h0,         5'd10, 32'hFFFF_DEAD, 0));
        vecs.push_back(mk(0, 3'b101, 32'h0000_0102, 12'h000, 32'h0,         5'd11, 32'h0000_DEAD, 0));
        vecs.push_back(mk(0, 3'b010, 32'h0000_0104, 12'hFFC, 32'h0,         5'd12, 32'hDEAD_BEEF, 0));
        vecs.push_back(mk(0, 3'b010, 32'h0000_03FE, 12'h000, 32'h0,         5'd13, 32'h0000_0000, 1));
        vecs.push_back(mk(0, 3'b001, 32'h0000_0101, 12'h000, 32'h0,         5'd14, 32'h0000_0000, 1));
        vecs.push_back(mk(0, 3'b011, 32'h0000_0100, 12'h000, 32'h0,         5'd15, 32'h0000_0000, 1));
        vecs.push_back(mk(1, 3'b011, 32'h0000_0100, 12'h000, 32'h1234_5678, 5'd16, 32'h0000_0000, 1));
        vecs.push_back(mk(0, 3'b110, 32'h0000_0100, 12'h000, 32'h0,         5'd17, 32'h0000_0000, 1));
        vecs.push_back(mk(1, 3'b100, 32'h0000_0100, 12'h000, 32'h1234_5678, 5'd27, 32'h0000_0000, 1));
        vecs.push_back(mk(1, 3'b000, 32'h0000_03FF, 12'h000, 32'h1234_5680, 5'd18, 32'h0000_0000, 0));
        vecs.push_back(mk(0, 3'b000, 32'h0000_03FF, 12'h000, 32'h0,         5'd19, 32'hFFFF_FF80, 0));
        vecs.push_back(mk(0, 3'b010, 32'h0000_03FC, 12'h000, 32'h0,         5'd20, 32'h8000_0000, 0));
        vecs.push_back(mk(0, 3'b001, 32'h0000_03FE, 12'h000, 32'h0,         5'd26, 32'hFFFF_8000, 0));
        vecs.push_back(mk(1, 3'b001, 32'h0000_0200, 12'h000, 32'hCAFE_F00D, 5'd21, 32'h0000_0000, 0));
        vecs.push_back(mk(0, 3'b101, 32'h0000_0200, 12'h000, 32'h0,         5'd22, 32'h0000_F00D, 0));
        vecs.push_back(mk(0, 3'b100, 32'hFFFF_FFFF, 12'h001, 32'h0,         5'd23, 32'h0000_0000, 0));
        vecs.push_back(mk(0, 3'b010, 32'hFFFF_FFFC, 12'h000, 32'h0,         5'd24, 32'h0000_0000, 1));
        vecs.push_back(mk(1, 3'b000, 32'h0000_0400, 12'h000, 32'h55,        5'd25, 32'h0000_0000, 1));
        vecs.push_back(mk(0, 3'b010, 32'h0000_0400, 12'h000, 32'h0,         5'd28, 32'h0000_0000, 1));

        tick();
        tick();
        check("rst_load_req",  32'(mem_load_request), 32'd0);
        check("rst_write_req", 32'(mem_write_request), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_load_addr", mem_load_addr, 32'd0);
        check("rst_write_addr", mem_write_addr, 32'd0);
        check("rst_result_data", result_data, 32'd0);
        check("rst_result_tag", 32'(result_tag), 32'd0);
        reset_n = 1'b1;
        tick();
        check("ready_after_reset", 32'(issue_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            v  = vecs[i];
            lp = load_pulses;
            wp = write_pulses;
            ea = v.base + {{20{v.off[11]}}, v.off};
            issue_op(v, v.exp_err ? 2 : 4, 1'b1);
            issue_valid = 1'b0;
            wait_drain();
            if (v.exp_err) begin
                check("err_no_access", 32'(load_pulses + write_pulses), 32'(lp + wp));
            end else if (v.st) begin
                check("write_count", 32'(write_pulses), 32'(wp + 1));
                check("write_cycle", 32'(last_write_cyc), 32'(last_hs + 2));
                check("write_addr", last_write_addr, ea);
                check("write_data", last_write_data, v.sd);
                check("write_type", 32'(last_write_type), 32'(v.f3));
            end else begin
                check("load_count", 32'(load_pulses), 32'(lp + 1));
                check("load_cycle", 32'(last_load_cyc), 32'(last_hs + 2));
                check("load_addr", last_load_addr, ea);
            end
        end

        // Three ops back-to-back: completions 4 cycles apart, queue full after the third.
        r0 = results_seen;
        issue_op(mk(0, 3'b010, 32'h100, 12'h0, 32'h0, 5'd29, 32'hDEAD_BEEF, 0), 4, 1'b1);
        issue_op(mk(0, 3'b010, 32'h200, 12'h0, 32'h0, 5'd30, 32'h0000_F00D, 0), 7, 1'b1);
        issue_op(mk(0, 3'b010, 32'h3FC, 12'h0, 32'h0, 5'd31, 32'h8000_0000, 0), 10, 1'b1);
        check("ready_full", 32'(issue_ready), 32'd0);
        issue_valid = 1'b0;
        wait_drain();
        check("b2b_results", 32'(results_seen), 32'(r0 + 3));

        // Flush while a store is in WAIT with a load still queued.
        r0 = results_seen;
        lp = load_pulses;
        wp = write_pulses;
        issue_op(mk(1, 3'b010, 32'h300, 12'h0, 32'h1122_3344, 5'd3, 32'h0, 0), 0, 1'b0);
        issue_op(mk(0, 3'b010, 32'h300, 12'h0, 32'h0, 5'd4, 32'h0, 0), 0, 1'b0);
        issue_valid = 1'b0;
        tick();
        flush = 1'b1;
        #1;
        check("ready_in_flush", 32'(issue_ready), 32'd0);
        tick();
        flush = 1'b0;
        repeat (8) tick();
        check("flush_no_result", 32'(results_seen), 32'(r0));
        check("flush_store_done", 32'(write_pulses), 32'(wp + 1));
        check("flush_load_dropped", 32'(load_pulses), 32'(lp));
        check("flush_mem_word", {mem[10'h303], mem[10'h302], mem[10'h301], mem[10'h300]}, 32'h1122_3344);
        check("flush_ready", 32'(issue_ready), 32'd1);
        issue_op(mk(0, 3'b010, 32'h300, 12'h0, 32'h0, 5'd4, 32'h1122_3344, 0), 4, 1'b1);
        issue_valid = 1'b0;
        wait_drain();

        // Reset during ISSUE drops the request at once and loses the op.
        r0 = results_seen;
        issue_op(mk(0, 3'b010, 32'h100, 12'h0, 32'h0, 5'd5, 32'h0, 0), 0, 1'b0);
        issue_valid = 1'b0;
        tick();
        check("req_in_issue", 32'(mem_load_request), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_drops_load_req", 32'(mem_load_request), 32'd0);
        check("rst_drops_write_req", 32'(mem_write_request), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (8) tick();
        check("rst_no_result", 32'(results_seen), 32'(r0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
